// File: rtl/sport_pkg.sv
// sport_pkg: shared constants for the SPORT control-register bank.
//   Register offsets, CTRL bit positions, MWORD field layout, AC97/I2S
//   preset register values and the per-channel commit FSM encoding.
package sport_pkg;

    // Field widths
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned AUTO_W = 12;
    localparam int unsigned WCNT_W = 3;
    localparam int unsigned SLOT_W = 4;

    // Register offsets within a channel
    localparam logic [OFF_W-1:0] OFF_AUTO    = 3'd0;
    localparam logic [OFF_W-1:0] OFF_FSDIV   = 3'd1;
    localparam logic [OFF_W-1:0] OFF_SCLKDIV = 3'd2;
    localparam logic [OFF_W-1:0] OFF_SCTL    = 3'd3;
    localparam logic [OFF_W-1:0] OFF_MWORD   = 3'd4;
    localparam logic [OFF_W-1:0] OFF_CTRL    = 3'd5;

    // CTRL bit indices
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_FORCE = 1;
    localparam int unsigned CTRL_IMM   = 2;
    localparam int unsigned CTRL_RDSH  = 3;

    // MWORD layout: [15:13] and [7:0] are storage, [11:8] shows the AC97 slot
    localparam logic [15:0]  MWORD_KEEP_MASK = 16'hE0FF;
    localparam int unsigned  MWORD_AC97_BIT  = 14;
    localparam int unsigned  MWORD_MODE_BIT  = 13;
    localparam int unsigned  MWORD_I2S_BIT   = 12;
    localparam int unsigned  MWORD_SLOT_LSB  = 8;

    // AC97 preset: 256-bit frame, framed multichannel transfer
    localparam logic [15:0] AC97_FSDIV = 16'h00FF;
    localparam logic [15:0] AC97_SCTL  = 16'h4C0F;
    localparam logic [15:0] AC97_MWORD = 16'h4000;

    // I2S preset: 32-bit frame, two words per frame
    localparam logic [15:0] I2S_FSDIV  = 16'h001F;
    localparam logic [15:0] I2S_SCTL   = 16'h2C0F;
    localparam logic [15:0] I2S_MWORD  = 16'h0002;

    // Commit FSM
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [WCNT_W-1:0] WCNT_MAX = 3'd7;

endpackage

// File: rtl/sport_ch_regs.sv
// sport_ch_regs: one SPORT channel's shadow/active register pair, CTRL,
// commit FSM and write counter.
//   clk, rst_n      : clock, synchronous active-low reset
//   reg_we          : write strobe for offsets 0-4 (already address-qualified)
//   ctrl_we         : write strobe for CTRL (already address-qualified)
//   wr_off, wr_data : write offset and data
//   frame_sync      : frame-boundary pulse from this channel's SPORT core
//   *_sh / *_act    : shadow and active register copies
//   en, imm, rdsh   : stored CTRL bits
//   pend            : uncommitted shadow write present
//   wcnt            : writes since last commit, saturating
module sport_ch_regs
    import sport_pkg::*;
#(
    parameter int unsigned DW     = 16,
    parameter int unsigned PRESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_we,
    input  logic              ctrl_we,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DW-1:0]     wr_data,
    input  logic              frame_sync,
    output logic [AUTO_W-1:0] auto_sh,
    output logic [AUTO_W-1:0] auto_act,
    output logic [DW-1:0]     fsdiv_sh,
    output logic [DW-1:0]     fsdiv_act,
    output logic [DW-1:0]     sclkdiv_sh,
    output logic [DW-1:0]     sclkdiv_act,
    output logic [DW-1:0]     sctl_sh,
    output logic [DW-1:0]     sctl_act,
    output logic [DW-1:0]     mword_sh,
    output logic [DW-1:0]     mword_act,
    output logic              en,
    output logic              imm,
    output logic              rdsh,
    output logic              pend,
    output logic [WCNT_W-1:0] wcnt
);

    logic [AUTO_W-1:0] auto_sh_q, auto_sh_d, auto_act_q, auto_act_d;
    logic [DW-1:0]     fsdiv_sh_q, fsdiv_sh_d, fsdiv_act_q, fsdiv_act_d;
    logic [DW-1:0]     sclkdiv_sh_q, sclkdiv_sh_d, sclkdiv_act_q, sclkdiv_act_d;
    logic [DW-1:0]     sctl_sh_q, sctl_sh_d, sctl_act_q, sctl_act_d;
    logic [DW-1:0]     mword_sh_q, mword_sh_d, mword_act_q, mword_act_d;
    logic              en_q, en_d, imm_q, imm_d, rdsh_q, rdsh_d;
    logic [0:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic en_nxt_c, imm_nxt_c, force_c, commit_c;

    // Commit conditions see a CTRL write in the same cycle, so disabling or
    // forcing commits on the edge of the CTRL write itself.
    assign en_nxt_c  = ctrl_we ? wr_data[CTRL_EN]  : en_q;
    assign imm_nxt_c = ctrl_we ? wr_data[CTRL_IMM] : imm_q;
    assign force_c   = ctrl_we & wr_data[CTRL_FORCE];
    assign commit_c  = (state_q == ST_PEND) &&
                       (frame_sync || !en_nxt_c || force_c || imm_nxt_c);

    // Next-state: commit copies pre-write shadow; a concurrent write lands in shadow
    always_comb begin
        auto_sh_d     = auto_sh_q;
        fsdiv_sh_d    = fsdiv_sh_q;
        sclkdiv_sh_d  = sclkdiv_sh_q;
        sctl_sh_d     = sctl_sh_q;
        mword_sh_d    = mword_sh_q;
        auto_act_d    = auto_act_q;
        fsdiv_act_d   = fsdiv_act_q;
        sclkdiv_act_d = sclkdiv_act_q;
        sctl_act_d    = sctl_act_q;
        mword_act_d   = mword_act_q;
        en_d          = en_q;
        imm_d         = imm_q;
        rdsh_d        = rdsh_q;
        state_d       = state_q;
        wcnt_d        = wcnt_q;

        if (commit_c) begin
            auto_act_d    = auto_sh_q;
            fsdiv_act_d   = fsdiv_sh_q;
            sclkdiv_act_d = sclkdiv_sh_q;
            sctl_act_d    = sctl_sh_q;
            mword_act_d   = mword_sh_q;
        end

        if (ctrl_we) begin
            en_d   = wr_data[CTRL_EN];
            imm_d  = wr_data[CTRL_IMM];
            rdsh_d = wr_data[CTRL_RDSH];
        end

        if (reg_we) begin
            case (wr_off)
                OFF_AUTO:    auto_sh_d    = wr_data[AUTO_W-1:0];
                OFF_FSDIV:   fsdiv_sh_d   = wr_data;
                OFF_SCLKDIV: sclkdiv_sh_d = wr_data;
                OFF_SCTL:    sctl_sh_d    = wr_data;
                OFF_MWORD: begin
                    // AC97 preset wins over I2S when both mode bits are set
                    if ((PRESET != 0) && wr_data[MWORD_AC97_BIT]) begin
                        fsdiv_sh_d = DW'(AC97_FSDIV);
                        sctl_sh_d  = DW'(AC97_SCTL);
                        mword_sh_d = DW'(AC97_MWORD);
                        mword_sh_d[MWORD_MODE_BIT] = mword_sh_d[MWORD_MODE_BIT] |
                                                     wr_data[MWORD_MODE_BIT];
                    end else if ((PRESET != 0) && wr_data[MWORD_I2S_BIT]) begin
                        fsdiv_sh_d = DW'(I2S_FSDIV);
                        sctl_sh_d  = DW'(I2S_SCTL);
                        mword_sh_d = DW'(I2S_MWORD);
                    end else begin
                        mword_sh_d = wr_data & DW'(MWORD_KEEP_MASK);
                    end
                end
                default: ;
            endcase
            state_d = ST_PEND;
            if (commit_c) begin
                wcnt_d = WCNT_W'(1);
            end else if (wcnt_q != WCNT_MAX) begin
                wcnt_d = wcnt_q + WCNT_W'(1);
            end
        end else if (commit_c) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_sh_q     <= '0;
            fsdiv_sh_q    <= '0;
            sclkdiv_sh_q  <= '0;
            sctl_sh_q     <= '0;
            mword_sh_q    <= '0;
            auto_act_q    <= '0;
            fsdiv_act_q   <= '0;
            sclkdiv_act_q <= '0;
            sctl_act_q    <= '0;
            mword_act_q   <= '0;
            en_q          <= 1'b0;
            imm_q         <= 1'b0;
            rdsh_q        <= 1'b0;
            state_q       <= ST_IDLE;
            wcnt_q        <= '0;
        end else begin
            auto_sh_q     <= auto_sh_d;
            fsdiv_sh_q    <= fsdiv_sh_d;
            sclkdiv_sh_q  <= sclkdiv_sh_d;
            sctl_sh_q     <= sctl_sh_d;
            mword_sh_q    <= mword_sh_d;
            auto_act_q    <= auto_act_d;
            fsdiv_act_q   <= fsdiv_act_d;
            sclkdiv_act_q <= sclkdiv_act_d;
            sctl_act_q    <= sctl_act_d;
            mword_act_q   <= mword_act_d;
            en_q          <= en_d;
            imm_q         <= imm_d;
            rdsh_q        <= rdsh_d;
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
        end
    end

    assign auto_sh     = auto_sh_q;
    assign auto_act    = auto_act_q;
    assign fsdiv_sh    = fsdiv_sh_q;
    assign fsdiv_act   = fsdiv_act_q;
    assign sclkdiv_sh  = sclkdiv_sh_q;
    assign sclkdiv_act = sclkdiv_act_q;
    assign sctl_sh     = sctl_sh_q;
    assign sctl_act    = sctl_act_q;
    assign mword_sh    = mword_sh_q;
    assign mword_act   = mword_act_q;
    assign en          = en_q;
    assign imm         = imm_q;
    assign rdsh        = rdsh_q;
    assign pend        = (state_q == ST_PEND);
    assign wcnt        = wcnt_q;

endmodule

// File: rtl/sport_ctl_bank.sv
// sport_ctl_bank: NCH-channel SPORT control-register bank with shadowed,
// frame-aligned commit of serial timing registers.
//   DSPCLK, RST          : clock, synchronous active-low reset
//   MMR_ADDR             : {channel, offset[2:0]}
//   MMR_WE, MMR_RE, DMD  : MMR write/read strobes and write data
//   DMD_do               : registered read data, held between reads
//   FRAME_SYNC, SLOT_NUM : per-channel frame pulse and AC97 slot from the cores
//   *_ACT, EN_ACT        : channel-packed active registers to the cores
//   PEND, WCNT           : per-channel pending flag and write count
module sport_ctl_bank
    import sport_pkg::*;
#(
    parameter int unsigned NCH    = 2,
    parameter int unsigned DW     = 16,
    parameter int unsigned PRESET = 1
) (
    input  logic                    DSPCLK,
    input  logic                    RST,
    input  logic [$clog2(NCH)+2:0]  MMR_ADDR,
    input  logic                    MMR_WE,
    input  logic                    MMR_RE,
    input  logic [DW-1:0]           DMD,
    output logic [DW-1:0]           DMD_do,
    input  logic [NCH-1:0]          FRAME_SYNC,
    input  logic [NCH*SLOT_W-1:0]   SLOT_NUM,
    output logic [NCH*DW-1:0]       SCTL_ACT,
    output logic [NCH*DW-1:0]       FSDIV_ACT,
    output logic [NCH*DW-1:0]       SCLKDIV_ACT,
    output logic [NCH*DW-1:0]       MWORD_ACT,
    output logic [NCH*AUTO_W-1:0]   AUTO_ACT,
    output logic [NCH-1:0]          EN_ACT,
    output logic [NCH-1:0]          PEND,
    output logic [NCH*WCNT_W-1:0]   WCNT
);

    localparam int unsigned AW = $clog2(NCH) + 3;

    logic [AUTO_W-1:0] auto_sh [NCH];
    logic [AUTO_W-1:0] auto_act [NCH];
    logic [DW-1:0]     fsdiv_sh [NCH];
    logic [DW-1:0]     fsdiv_act [NCH];
    logic [DW-1:0]     sclkdiv_sh [NCH];
    logic [DW-1:0]     sclkdiv_act [NCH];
    logic [DW-1:0]     sctl_sh [NCH];
    logic [DW-1:0]     sctl_act [NCH];
    logic [DW-1:0]     mword_sh [NCH];
    logic [DW-1:0]     mword_act [NCH];
    logic [NCH-1:0]    ch_en, ch_imm, ch_rdsh, ch_pend;
    logic [WCNT_W-1:0] ch_wcnt [NCH];

    logic [AW-1:0]     ch_raw_c;
    logic [OFF_W-1:0]  off_c;
    logic              addr_ok_c;
    logic [NCH-1:0]    reg_we_c, ctrl_we_c;
    logic [DW-1:0]     rd_val_c, mword_sel_c;
    logic [DW-1:0]     rd_q, rd_d;

    // Address decode; channel field is everything above the offset
    assign off_c     = MMR_ADDR[OFF_W-1:0];
    assign ch_raw_c  = MMR_ADDR >> OFF_W;
    assign addr_ok_c = (ch_raw_c < AW'(NCH)) && (off_c <= OFF_CTRL);

    // Per-channel write strobes
    always_comb begin
        reg_we_c  = '0;
        ctrl_we_c = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (MMR_WE && addr_ok_c && (ch_raw_c == AW'(c))) begin
                reg_we_c[c]  = (off_c != OFF_CTRL);
                ctrl_we_c[c] = (off_c == OFF_CTRL);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        sport_ch_regs #(
            .DW     (DW),
            .PRESET (PRESET)
        ) u_ch (
            .clk         (DSPCLK),
            .rst_n       (RST),
            .reg_we      (reg_we_c[g]),
            .ctrl_we     (ctrl_we_c[g]),
            .wr_off      (off_c),
            .wr_data     (DMD),
            .frame_sync  (FRAME_SYNC[g]),
            .auto_sh     (auto_sh[g]),
            .auto_act    (auto_act[g]),
            .fsdiv_sh    (fsdiv_sh[g]),
            .fsdiv_act   (fsdiv_act[g]),
            .sclkdiv_sh  (sclkdiv_sh[g]),
            .sclkdiv_act (sclkdiv_act[g]),
            .sctl_sh     (sctl_sh[g]),
            .sctl_act    (sctl_act[g]),
            .mword_sh    (mword_sh[g]),
            .mword_act   (mword_act[g]),
            .en          (ch_en[g]),
            .imm         (ch_imm[g]),
            .rdsh        (ch_rdsh[g]),
            .pend        (ch_pend[g]),
            .wcnt        (ch_wcnt[g])
        );

        assign SCTL_ACT[g*DW +: DW]            = sctl_act[g];
        assign FSDIV_ACT[g*DW +: DW]           = fsdiv_act[g];
        assign SCLKDIV_ACT[g*DW +: DW]         = sclkdiv_act[g];
        assign MWORD_ACT[g*DW +: DW]           = mword_act[g];
        assign AUTO_ACT[g*AUTO_W +: AUTO_W]    = auto_act[g];
        assign EN_ACT[g]                       = ch_en[g];
        assign PEND[g]                         = ch_pend[g];
        assign WCNT[g*WCNT_W +: WCNT_W]        = ch_wcnt[g];
    end

    // Read mux: RDSH picks shadow or active; CTRL is read directly, FORCE as 0
    always_comb begin
        rd_val_c    = '0;
        mword_sel_c = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (addr_ok_c && (ch_raw_c == AW'(c))) begin
                case (off_c)
                    OFF_AUTO:    rd_val_c = DW'(ch_rdsh[c] ? auto_sh[c] : auto_act[c]);
                    OFF_FSDIV:   rd_val_c = ch_rdsh[c] ? fsdiv_sh[c] : fsdiv_act[c];
                    OFF_SCLKDIV: rd_val_c = ch_rdsh[c] ? sclkdiv_sh[c] : sclkdiv_act[c];
                    OFF_SCTL:    rd_val_c = ch_rdsh[c] ? sctl_sh[c] : sctl_act[c];
                    OFF_MWORD: begin
                        mword_sel_c = ch_rdsh[c] ? mword_sh[c] : mword_act[c];
                        rd_val_c    = mword_sel_c;
                        // AC97 mode overlays the live slot number on the unused field
                        if (mword_sel_c[MWORD_AC97_BIT]) begin
                            rd_val_c[MWORD_SLOT_LSB +: SLOT_W] = SLOT_NUM[c*SLOT_W +: SLOT_W];
                        end
                    end
                    OFF_CTRL:    rd_val_c = DW'({ch_rdsh[c], ch_imm[c], 1'b0, ch_en[c]});
                    default:     rd_val_c = '0;
                endcase
            end
        end
    end

    // Read data holds until the next read strobe
    always_comb begin
        rd_d = rd_q;
        if (MMR_RE) begin
            rd_d = rd_val_c;
        end
    end

    always_ff @(posedge DSPCLK) begin
        if (!RST) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign DMD_do = rd_q;

endmodule

// File: tb/tb_sport_ctl_bank.sv
// tb_sport_ctl_bank: directed bench for sport_ctl_bank with a register-level
// reference model checked every cycle plus literal spot checks.
module tb_sport_ctl_bank;
    import sport_pkg::*;

    localparam int NCH = 3;
    localparam int DW  = 16;

    logic          DSPCLK = 1'b0;
    logic          RST;
    logic [4:0]    MMR_ADDR;
    logic          MMR_WE, MMR_RE;
    logic [15:0]   DMD;
    logic [15:0]   DMD_do;
    logic [2:0]    FRAME_SYNC;
    logic [11:0]   SLOT_NUM;
    logic [47:0]   SCTL_ACT, FSDIV_ACT, SCLKDIV_ACT, MWORD_ACT;
    logic [35:0]   AUTO_ACT;
    logic [2:0]    EN_ACT, PEND;
    logic [8:0]    WCNT;

    sport_ctl_bank #(.NCH(NCH), .DW(DW), .PRESET(1)) dut (
        .DSPCLK      (DSPCLK),
        .RST         (RST),
        .MMR_ADDR    (MMR_ADDR),
        .MMR_WE      (MMR_WE),
        .MMR_RE      (MMR_RE),
        .DMD         (DMD),
        .DMD_do      (DMD_do),
        .FRAME_SYNC  (FRAME_SYNC),
        .SLOT_NUM    (SLOT_NUM),
        .SCTL_ACT    (SCTL_ACT),
        .FSDIV_ACT   (FSDIV_ACT),
        .SCLKDIV_ACT (SCLKDIV_ACT),
        .MWORD_ACT   (MWORD_ACT),
        .AUTO_ACT    (AUTO_ACT),
        .EN_ACT      (EN_ACT),
        .PEND        (PEND),
        .WCNT        (WCNT)
    );

    always #5 DSPCLK = ~DSPCLK;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // Model: registers indexed by offset 0..4 (AUTO, FSDIV, SCLKDIV, SCTL, MWORD)
    logic [15:0] m_sh  [NCH][5];
    logic [15:0] m_act [NCH][5];
    logic        m_en [NCH], m_imm [NCH], m_rdsh [NCH], m_pend [NCH];
    int          m_wcnt [NCH];
    logic [15:0] m_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input int ch, input int off);
        logic [15:0] v;
        if (ch >= NCH || off > 5) return 16'h0000;
        if (off == 5) return {12'h000, m_rdsh[ch], m_imm[ch], 1'b0, m_en[ch]};
        v = m_rdsh[ch] ? m_sh[ch][off] : m_act[ch][off];
        if (off == 4 && v[14]) v[11:8] = SLOT_NUM[ch*4 +: 4];
        return v;
    endfunction

    task automatic shadow_write(input int c, input int off, input logic [15:0] d);
        if (off == 0) begin
            m_sh[c][0] = d & 16'h0FFF;
        end else if (off == 4) begin
            if (d[14]) begin
                m_sh[c][1] = AC97_FSDIV;
                m_sh[c][3] = AC97_SCTL;
                m_sh[c][4] = AC97_MWORD | (d & 16'h2000);
            end else if (d[12]) begin
                m_sh[c][1] = I2S_FSDIV;
                m_sh[c][3] = I2S_SCTL;
                m_sh[c][4] = I2S_MWORD;
            end else begin
                m_sh[c][4] = d & 16'hE0FF;
            end
        end else begin
            m_sh[c][off] = d;
        end
    endtask

    // Advance the model by one clock edge using the current inputs
    task automatic model_step();
        int ch, off;
        logic ok, wr_this, ctl_this, new_en, new_imm, frc, commit;
        ch  = int'(MMR_ADDR) / 8;
        off = int'(MMR_ADDR) % 8;
        if (!RST) begin
            for (int c = 0; c < NCH; c++) begin
                for (int r = 0; r < 5; r++) begin
                    m_sh[c][r]  = 16'h0;
                    m_act[c][r] = 16'h0;
                end
                m_en[c] = 0; m_imm[c] = 0; m_rdsh[c] = 0; m_pend[c] = 0; m_wcnt[c] = 0;
            end
            m_rd = 16'h0;
            return;
        end
        ok = (ch < NCH) && (off <= 5);
        if (MMR_RE) m_rd = model_read(ch, off);
        for (int c = 0; c < NCH; c++) begin
            wr_this  = MMR_WE && ok && (ch == c) && (off < 5);
            ctl_this = MMR_WE && ok && (ch == c) && (off == 5);
            new_en   = ctl_this ? DMD[0] : m_en[c];
            new_imm  = ctl_this ? DMD[2] : m_imm[c];
            frc      = ctl_this && DMD[1];
            commit   = m_pend[c] && (FRAME_SYNC[c] || !new_en || frc || new_imm);
            if (commit) for (int r = 0; r < 5; r++) m_act[c][r] = m_sh[c][r];
            if (ctl_this) begin
                m_en[c] = DMD[0]; m_imm[c] = DMD[2]; m_rdsh[c] = DMD[3];
            end
            if (wr_this) begin
                shadow_write(c, off, DMD);
                m_pend[c] = 1'b1;
                m_wcnt[c] = commit ? 1 : ((m_wcnt[c] < 7) ? m_wcnt[c] + 1 : 7);
            end else if (commit) begin
                m_pend[c] = 1'b0;
                m_wcnt[c] = 0;
            end
        end
    endtask

    logic [47:0] e_sctl, e_fsdiv, e_sclk, e_mword;
    logic [35:0] e_auto;
    logic [2:0]  e_en, e_pend;
    logic [8:0]  e_wcnt;

    // Every-cycle comparison against the model
    always @(negedge DSPCLK) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                e_auto[c*12 +: 12]  = m_act[c][0][11:0];
                e_fsdiv[c*16 +: 16] = m_act[c][1];
                e_sclk[c*16 +: 16]  = m_act[c][2];
                e_sctl[c*16 +: 16]  = m_act[c][3];
                e_mword[c*16 +: 16] = m_act[c][4];
                e_en[c]             = m_en[c];
                e_pend[c]           = m_pend[c];
                e_wcnt[c*3 +: 3]    = 3'(m_wcnt[c]);
            end
            chk("AUTO_ACT",    64'(AUTO_ACT),    64'(e_auto));
            chk("FSDIV_ACT",   64'(FSDIV_ACT),   64'(e_fsdiv));
            chk("SCLKDIV_ACT", 64'(SCLKDIV_ACT), 64'(e_sclk));
            chk("SCTL_ACT",    64'(SCTL_ACT),    64'(e_sctl));
            chk("MWORD_ACT",   64'(MWORD_ACT),   64'(e_mword));
            chk("EN_ACT",      64'(EN_ACT),      64'(e_en));
            chk("PEND",        64'(PEND),        64'(e_pend));
            chk("WCNT",        64'(WCNT),        64'(e_wcnt));
            chk("DMD_do",      64'(DMD_do),      64'(m_rd));
        end
    end

    task automatic cyc(input logic we, input logic re, input int ch, input int off,
                       input logic [15:0] d, input logic [2:0] fs);
        MMR_WE     = we;
        MMR_RE     = re;
        MMR_ADDR   = 5'(ch * 8 + off);
        DMD        = d;
        FRAME_SYNC = fs;
        model_step();
        @(posedge DSPCLK);
        @(negedge DSPCLK);
        #1;
    endtask

    task automatic wr(input int ch, input int off, input logic [15:0] d);
        cyc(1'b1, 1'b0, ch, off, d, 3'b000);
    endtask

    task automatic rd(input int ch, input int off);
        cyc(1'b0, 1'b1, ch, off, 16'h0000, 3'b000);
    endtask

    task automatic idle(input logic [2:0] fs);
        cyc(1'b0, 1'b0, 0, 0, 16'h0000, fs);
    endtask

    initial begin
        RST = 1'b0; MMR_WE = 1'b0; MMR_RE = 1'b0; MMR_ADDR = '0;
        DMD = '0; FRAME_SYNC = '0; SLOT_NUM = '0;
        chk_en = 1'b1;

        // Reset
        idle(3'b000);
        idle(3'b000);
        chk("rst_fsdiv", 64'(FSDIV_ACT), 64'h0);
        chk("rst_pend",  64'(PEND),      64'h0);
        chk("rst_dmd",   64'(DMD_do),    64'h0);
        RST = 1'b1;

        // Frame-aligned commit on ch0
        wr(0, 5, 16'h0001);
        wr(0, 1, 16'h00FF);
        chk("fc_fsdiv_held", 64'(FSDIV_ACT[15:0]), 64'h0000);
        chk("fc_pend_set",   64'(PEND[0]),         64'h1);
        idle(3'b001);
        chk("fc_fsdiv_act",  64'(FSDIV_ACT[15:0]), 64'h00FF);
        chk("fc_pend_clr",   64'(PEND[0]),         64'h0);
        chk("fc_wcnt_clr",   64'(WCNT[2:0]),       64'h0);

        // Commit colliding with a new write on ch1
        wr(1, 5, 16'h0001);
        wr(1, 3, 16'h1234);
        cyc(1'b1, 1'b0, 1, 3, 16'h5678, 3'b010);
        chk("col_sctl_old", 64'(SCTL_ACT[31:16]), 64'h1234);
        chk("col_pend",     64'(PEND[1]),         64'h1);
        chk("col_wcnt",     64'(WCNT[5:3]),       64'h1);
        idle(3'b010);
        chk("col_sctl_new", 64'(SCTL_ACT[31:16]), 64'h5678);

        // AC97 preset with forced commit, then slot readback
        wr(0, 4, 16'h6000);
        wr(0, 5, 16'h0003);
        chk("ac97_mword", 64'(MWORD_ACT[15:0]), 64'h6000);
        chk("ac97_sctl",  64'(SCTL_ACT[15:0]),  64'(AC97_SCTL));
        SLOT_NUM = 12'h005;
        rd(0, 4);
        chk("ac97_slot_rd", 64'(DMD_do), 64'h6500);

        // I2S preset on ch2 plus AUTO, committed by IMM on the CTRL write
        wr(2, 5, 16'h0001);
        wr(2, 0, 16'hFABC);
        wr(2, 4, 16'h1000);
        wr(2, 5, 16'h0005);
        chk("i2s_fsdiv", 64'(FSDIV_ACT[47:32]), 64'(I2S_FSDIV));
        chk("i2s_mword", 64'(MWORD_ACT[47:32]), 64'(I2S_MWORD));
        chk("auto_act",  64'(AUTO_ACT[35:24]),  64'hABC);
        rd(2, 0);
        chk("auto_rd",   64'(DMD_do),           64'h0ABC);

        // WCNT saturation and shadow/active readback on ch1
        for (int i = 1; i <= 9; i++) wr(1, 1, 16'(i));
        chk("sat_wcnt",  64'(WCNT[5:3]),        64'h7);
        chk("sat_act",   64'(FSDIV_ACT[31:16]), 64'h0000);
        wr(1, 5, 16'h0009);
        rd(1, 1);
        chk("rdsh_rd",   64'(DMD_do), 64'h0009);
        idle(3'b000);
        chk("rd_hold",   64'(DMD_do), 64'h0009);
        cyc(1'b1, 1'b1, 1, 1, 16'h00AA, 3'b000);
        chk("rw_prewr",  64'(DMD_do), 64'h0009);
        rd(1, 1);
        chk("rw_postwr", 64'(DMD_do), 64'h00AA);
        wr(1, 5, 16'h0001);
        rd(1, 1);
        chk("act_rd",    64'(DMD_do), 64'h0000);
        wr(1, 5, 16'h0000);
        chk("dis_commit", 64'(FSDIV_ACT[31:16]), 64'h00AA);
        chk("dis_pend",   64'(PEND[1]),          64'h0);
        chk("dis_wcnt",   64'(WCNT[5:3]),        64'h0);

        // Out-of-range channel and reserved offsets
        rd(0, 1);
        chk("pre_bad_rd", 64'(DMD_do), 64'h00FF);
        wr(3, 1, 16'hFFFF);
        wr(3, 5, 16'hFFFF);
        wr(0, 7, 16'hFFFF);
        wr(0, 6, 16'hFFFF);
        chk("bad_pend", 64'(PEND), 64'h0);
        chk("bad_wcnt", 64'(WCNT), 64'h0);
        rd(3, 1);
        chk("bad_ch_rd", 64'(DMD_do), 64'h0000);
        rd(0, 1);
        rd(0, 7);
        chk("bad_off_rd", 64'(DMD_do), 64'h0000);

        // Reset while a write is pending
        wr(0, 2, 16'h4321);
        chk("rp_pend", 64'(PEND[0]), 64'h1);
        RST = 1'b0;
        idle(3'b000);
        RST = 1'b1;
        chk("rp_fsdiv", 64'(FSDIV_ACT), 64'h0);
        chk("rp_pend0", 64'(PEND),      64'h0);
        wr(0, 5, 16'h0008);
        rd(0, 2);
        chk("rp_shadow", 64'(DMD_do), 64'h0000);
        idle(3'b000);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
